// File: rtl/conv_pkg.sv
//==============================================================================
// Module      : conv_pkg
// Description : Shared widths and types for the convolution datapath.
//               Optional build macro used by this block: CONV_SAT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package conv_pkg;

    localparam int ADDR_W = 5;                    // X/Y address width
    localparam int DATA_W = 8;                    // signed sample width
    localparam int Z_W    = 2 * DATA_W;           // signed output width
    localparam int ACC_W  = 2 * DATA_W + ADDR_W;  // accumulator, cannot overflow

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic        [ADDR_W+1:0] kidx_t;     // k and j counters

endpackage

`default_nettype wire

// File: rtl/convolution_datapath_if.sv
//==============================================================================
// Module      : convolution_datapath_if
// Description : Memory-side bus of the convolution datapath: X/Y asynchronous
//               read ports and the Z write port.
//               Optional build macro used by this block: CONV_SAT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface convolution_datapath_if;
    import conv_pkg::*;

    logic [ADDR_W-1:0]       addr_x;
    logic [ADDR_W-1:0]       addr_y;
    sample_t                 data_x;
    sample_t                 data_y;
    logic [ADDR_W:0]         addr_z;
    logic signed [Z_W-1:0]   data_z;
    logic                    we_z;

    // Datapath side: drives addresses and Z writes, receives sample data
    modport master (
        output addr_x, addr_y, addr_z, data_z, we_z,
        input  data_x, data_y
    );

    // Memory side
    modport slave (
        input  addr_x, addr_y, addr_z, data_z, we_z,
        output data_x, data_y
    );

endinterface

`default_nettype wire

// File: rtl/conv_mac.sv
//==============================================================================
// Module      : conv_mac
// Description : Signed multiply-accumulate with clear/enable and the reduction
//               of the accumulator to the Z output width.
//               CONV_SAT_EN defined   : clamp to Z range, sticky sat_o.
//               CONV_SAT_EN undefined : wrap (low Z_W bits), sat_o stays 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_mac
    import conv_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rstn,
    input  wire logic                  clr_z,
    input  wire logic                  enable_z,
    input  wire logic                  writeZ,
    input  wire sample_t               data_x,
    input  wire sample_t               data_y,
    output logic signed [Z_W-1:0]      data_z,
    output logic                       sat_o
);

    acc_t                         acc_q;
    acc_t                         acc_d;
    logic                         sat_q;
    logic                         sat_d;
    logic signed [2*DATA_W-1:0]   w_prod;
    logic                         w_clamp;
    logic signed [Z_W-1:0]        w_red;

    assign w_prod = data_x * data_y;

`ifdef CONV_SAT_EN
    localparam acc_t C_Z_MAX = acc_t'((2 ** (Z_W - 1)) - 1);
    localparam acc_t C_Z_MIN = acc_t'(-(2 ** (Z_W - 1)));

    // Clamp the accumulator into the signed Z range and flag when it did
    always_comb begin
        w_clamp = 1'b0;
        w_red   = acc_q[Z_W-1:0];
        if (acc_q > C_Z_MAX) begin
            w_clamp = 1'b1;
            w_red   = {1'b0, {(Z_W-1){1'b1}}};
        end else if (acc_q < C_Z_MIN) begin
            w_clamp = 1'b1;
            w_red   = {1'b1, {(Z_W-1){1'b0}}};
        end
    end
`else
    // Plain two's-complement wrap; clamping never happens
    assign w_clamp = 1'b0;
    assign w_red   = acc_q[Z_W-1:0];
`endif

    // Next accumulator and saturation state; clear has priority over enable
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_z)
            acc_d = '0;
        else if (enable_z)
            acc_d = acc_q + acc_t'(w_prod);
        if (clr_z)
            sat_d = 1'b0;
        else if (writeZ && w_clamp)
            sat_d = 1'b1;
    end

    // Accumulator and sticky saturation registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign data_z = w_red;
    assign sat_o  = sat_q;

endmodule

`default_nettype wire

// File: rtl/convolution_datapath.sv
//==============================================================================
// Module      : convolution_datapath
// Description : Convolution datapath z[k] = sum_j x[j]*y[k-j]. Owns the k/j
//               counters, window bounds, X/Y read addressing and Z write port;
//               the MAC lives in conv_mac. Sizes are frozen at clr_k.
//               Optional build macro: CONV_SAT_EN (saturating Z output).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module convolution_datapath
    import conv_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rstn,
    input  wire logic [ADDR_W:0]      sizeX,
    input  wire logic [ADDR_W:0]      sizeY,
    input  wire logic                 clr_k,
    input  wire logic                 enable_k,
    input  wire logic                 clr_j,
    input  wire logic                 enable_j,
    input  wire logic                 clr_z,
    input  wire logic                 enable_z,
    input  wire logic                 writeZ,
    output logic                      com_k_until,
    output logic                      flag_j_fin_w,
    output logic                      comp_o,
    output logic                      shape,
    output logic                      sat_o,
    convolution_datapath_if.master    mem
);

    // One extra bit over k so window bounds can go negative
    localparam int SW = ADDR_W + 3;
    typedef logic signed [SW-1:0] sidx_t;

    kidx_t              k_q, k_d;
    kidx_t              j_q, j_d;
    logic [ADDR_W:0]    size_x_q, size_y_q;
    logic [ADDR_W-1:0]  addr_x_q, addr_y_q;

    sidx_t              w_k_s, w_j_s, w_sx_s, w_sy_s;
    sidx_t              w_lo_raw, w_j_lo, w_sxm1, w_j_hi;
    kidx_t              w_len_z;

    // Window bounds: j_lo = max(0, k-sizeY+1), j_hi = min(k, sizeX-1)
    assign w_k_s    = sidx_t'({1'b0, k_q});
    assign w_j_s    = sidx_t'({1'b0, j_q});
    assign w_sx_s   = sidx_t'(size_x_q);
    assign w_sy_s   = sidx_t'(size_y_q);
    assign w_lo_raw = w_k_s + sidx_t'(1) - w_sy_s;
    assign w_j_lo   = w_lo_raw[SW-1] ? '0 : w_lo_raw;
    assign w_sxm1   = w_sx_s - sidx_t'(1);
    assign w_j_hi   = (w_k_s < w_sxm1) ? w_k_s : w_sxm1;

    // Loop status back to the FSM
    assign shape        = (|size_x_q) && (|size_y_q);
    assign w_len_z      = shape ? (kidx_t'(size_x_q) + kidx_t'(size_y_q) - kidx_t'(1)) : '0;
    assign com_k_until  = (k_q >= w_len_z);
    assign flag_j_fin_w = (w_j_s > w_j_hi);
    assign comp_o       = (w_j_lo > w_j_hi);

    // Next k and j; clears take priority over the matching enable
    always_comb begin
        k_d = k_q;
        j_d = j_q;
        if (clr_k)
            k_d = '0;
        else if (enable_k)
            k_d = k_q + kidx_t'(1);
        if (clr_j)
            j_d = kidx_t'(w_j_lo);
        else if (enable_j)
            j_d = j_q + kidx_t'(1);
    end

    // Counters, frozen configuration and registered read addresses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_q      <= '0;
            j_q      <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
        end else begin
            k_q <= k_d;
            j_q <= j_d;
            if (clr_k) begin
                size_x_q <= sizeX;
                size_y_q <= sizeY;
            end
            if (enable_j && !clr_j) begin
                addr_x_q <= j_q[ADDR_W-1:0];
                addr_y_q <= k_q[ADDR_W-1:0] - j_q[ADDR_W-1:0];
            end
        end
    end

    assign mem.addr_x = addr_x_q;
    assign mem.addr_y = addr_y_q;
    assign mem.addr_z = k_q[ADDR_W:0];
    assign mem.we_z   = writeZ;

    conv_mac u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .clr_z    (clr_z),
        .enable_z (enable_z),
        .writeZ   (writeZ),
        .data_x   (mem.data_x),
        .data_y   (mem.data_y),
        .data_z   (mem.data_z),
        .sat_o    (sat_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_convolution_datapath.sv
//==============================================================================
// Module      : tb_convolution_datapath
// Description : Directed bench for convolution_datapath. Plays the FSM role,
//               models X/Y/Z memories and checks results against hand values.
//               Expectations follow CONV_SAT_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_convolution_datapath;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [ADDR_W:0]   sizeX = '0;
    logic [ADDR_W:0]   sizeY = '0;
    logic              clr_k = 1'b0, enable_k = 1'b0, clr_j = 1'b0, enable_j = 1'b0;
    logic              clr_z = 1'b0, enable_z = 1'b0, writeZ = 1'b0;
    logic              com_k_until, flag_j_fin_w, comp_o, shape, sat_o;

    convolution_datapath_if mif ();

    convolution_datapath dut (
        .clk          (clk),
        .rstn         (rstn),
        .sizeX        (sizeX),
        .sizeY        (sizeY),
        .clr_k        (clr_k),
        .enable_k     (enable_k),
        .clr_j        (clr_j),
        .enable_j     (enable_j),
        .clr_z        (clr_z),
        .enable_z     (enable_z),
        .writeZ       (writeZ),
        .com_k_until  (com_k_until),
        .flag_j_fin_w (flag_j_fin_w),
        .comp_o       (comp_o),
        .shape        (shape),
        .sat_o        (sat_o),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    sample_t           xmem [32];
    sample_t           ymem [32];
    logic [Z_W-1:0]    zmem [64];
    int                wr_cnt = 0;

    assign mif.data_x = xmem[mif.addr_x];
    assign mif.data_y = ymem[mif.addr_y];

    // Z memory model with a write counter
    always @(posedge clk) begin
        if (mif.we_z) begin
            zmem[mif.addr_z] <= mif.data_z;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    int sat_seen;
    int w0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr_k = 1'b0; enable_k = 1'b0; clr_j = 1'b0; enable_j = 1'b0;
        clr_z = 1'b0; enable_z = 1'b0; writeZ = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Full FSM-style run; sizes on the ports are scrambled after capture
    task automatic run_conv(input logic [ADDR_W:0] sx, input logic [ADDR_W:0] sy);
        int n;
        int g;
        clr_k = 1'b1; sizeX = sx; sizeY = sy;
        tick();
        sizeX = 6'd7; sizeY = 6'd9;
        sat_seen = 0;
        n = 0;
        while (!com_k_until && n < 64) begin
            clr_z = 1'b1; clr_j = 1'b1;
            tick();
            g = 0;
            while (!flag_j_fin_w && g < 40) begin
                enable_j = 1'b1; tick();
                enable_z = 1'b1; tick();
                g++;
            end
            writeZ = 1'b1;
            tick();
            if (sat_o) sat_seen = 1;
            enable_k = 1'b1;
            tick();
            n++;
        end
        chk("run_done", 32'(com_k_until), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            xmem[i] = '0;
            ymem[i] = '0;
        end
        idle();
        rstn = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_shape",  32'(shape), 0);
        chk("rst_com_k",  32'(com_k_until), 1);
        chk("rst_we_z",   32'(mif.we_z), 0);
        chk("rst_addr_x", 32'(mif.addr_x), 0);
        chk("rst_addr_y", 32'(mif.addr_y), 0);
        chk("rst_addr_z", 32'(mif.addr_z), 0);
        chk("rst_data_z", 32'(mif.data_z), 0);
        chk("rst_sat",    32'(sat_o), 0);
        rstn = 1'b1;

        // x=[1,2,3], y=[1,1] -> z=[1,3,5,3]
        xmem[0] = 8'sd1; xmem[1] = 8'sd2; xmem[2] = 8'sd3;
        ymem[0] = 8'sd1; ymem[1] = 8'sd1;
        w0 = wr_cnt;
        run_conv(6'd3, 6'd2);
        chk("a_z0", 32'(zmem[0]), 32'h1);
        chk("a_z1", 32'(zmem[1]), 32'h3);
        chk("a_z2", 32'(zmem[2]), 32'h5);
        chk("a_z3", 32'(zmem[3]), 32'h3);
        chk("a_writes", wr_cnt - w0, 4);
        chk("a_k_end",  32'(mif.addr_z), 4);
        chk("a_shape_frozen", 32'(shape), 1);

        // clr_j beats enable_j at k=2, sizeY=2
        clr_k = 1'b1; sizeX = 6'd3; sizeY = 6'd2; tick();
        enable_k = 1'b1; tick();
        enable_k = 1'b1; tick();
        clr_j = 1'b1; tick();
        enable_j = 1'b1; tick();
        enable_j = 1'b1; tick();
        chk("cj_pre_addr_x", 32'(mif.addr_x), 2);
        chk("cj_pre_fin",    32'(flag_j_fin_w), 1);
        clr_j = 1'b1; enable_j = 1'b1; tick();
        chk("cj_addr_x_hold", 32'(mif.addr_x), 2);
        chk("cj_addr_y_hold", 32'(mif.addr_y), 0);
        chk("cj_fin_clear",   32'(flag_j_fin_w), 0);
        enable_j = 1'b1; tick();
        chk("cj_post_addr_x", 32'(mif.addr_x), 1);
        chk("cj_post_addr_y", 32'(mif.addr_y), 1);

        // Single sample: -4 * 5 = -20
        xmem[0] = -8'sd4; ymem[0] = 8'sd5;
        w0 = wr_cnt;
        run_conv(6'd1, 6'd1);
        chk("b_z0",     32'(zmem[0]), 32'hFFEC);
        chk("b_writes", wr_cnt - w0, 1);
        chk("b_k_end",  32'(mif.addr_z), 1);

        // Degenerate size: no writes at all
        w0 = wr_cnt;
        run_conv(6'd0, 6'd4);
        chk("c_shape",  32'(shape), 0);
        chk("c_com_k",  32'(com_k_until), 1);
        chk("c_writes", wr_cnt - w0, 0);

        // Overflow case: z[1] = 2 * 16384 = 32768
        xmem[0] = 8'sh80; xmem[1] = 8'sh80;
        ymem[0] = 8'sh80; ymem[1] = 8'sh80;
        w0 = wr_cnt;
        run_conv(6'd2, 6'd2);
        chk("d_z0", 32'(zmem[0]), 32'h4000);
`ifdef CONV_SAT_EN
        chk("d_z1",  32'(zmem[1]), 32'h7FFF);
        chk("d_sat", 32'(sat_seen), 1);
`else
        chk("d_z1",  32'(zmem[1]), 32'h8000);
        chk("d_sat", 32'(sat_seen), 0);
`endif
        chk("d_z2",     32'(zmem[2]), 32'h4000);
        chk("d_writes", wr_cnt - w0, 3);

        // Reset in the middle of a window, then rerun with new data
        xmem[0] = 8'sd2; xmem[1] = -8'sd1; xmem[2] = 8'sd3;
        ymem[0] = 8'sd1; ymem[1] = 8'sd1;
        clr_k = 1'b1; sizeX = 6'd3; sizeY = 6'd2; tick();
        clr_z = 1'b1; clr_j = 1'b1; tick();
        enable_j = 1'b1; tick();
        enable_z = 1'b1; tick();
        w0 = wr_cnt;
        enable_j = 1'b1; rstn = 1'b0; tick();
        rstn = 1'b1;
        chk("e_addr_x", 32'(mif.addr_x), 0);
        chk("e_shape",  32'(shape), 0);
        chk("e_com_k",  32'(com_k_until), 1);
        chk("e_data_z", 32'(mif.data_z), 0);
        chk("e_we_z",   32'(mif.we_z), 0);
        tick();
        chk("e_no_write", wr_cnt - w0, 0);
        run_conv(6'd3, 6'd2);
        chk("e_z0", 32'(zmem[0]), 32'h2);
        chk("e_z1", 32'(zmem[1]), 32'h1);
        chk("e_z2", 32'(zmem[2]), 32'h2);
        chk("e_z3", 32'(zmem[3]), 32'h3);
        chk("e_writes", wr_cnt - w0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
